// File: rtl/fanfare_seq.sv
// Piezo fanfare player: plays one of four fixed note tables as a square wave
// on a differential buzzer pair, repeating the tune reps+1 times.
module fanfare_seq #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DUR_SHIFT   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [1:0] tune,
  input  logic [1:0] reps,
  input  logic       abort,
  output logic       piezo,
  output logic       piezo_n,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, PLAY, NEXT} state_t;

  localparam logic [31:0] HALF_G6 = 32'(CLK_FREQ_HZ / (2 * 1568));
  localparam logic [31:0] HALF_C7 = 32'(CLK_FREQ_HZ / (2 * 2093));
  localparam logic [31:0] HALF_E7 = 32'(CLK_FREQ_HZ / (2 * 2637));
  localparam logic [31:0] HALF_G7 = 32'(CLK_FREQ_HZ / (2 * 3136));

  localparam logic [24:0] D22    = 25'd1 << 22;
  localparam logic [24:0] D23    = 25'd1 << 23;
  localparam logic [24:0] D24    = 25'd1 << 24;
  localparam logic [24:0] D23_22 = D23 + D22;

  state_t      state, state_next;
  logic [1:0]  tune_q, reps_q, rep_cnt;
  logic [2:0]  note_idx, note_last;
  logic [24:0] dur_cnt, dur_full, dur_cur;
  logic [31:0] tone_cnt, half_cur;
  logic        tone_q;
  logic        last_note, last_rep, finish, sounding;

  // Note table lookup for the latched tune; tune 3 has no notes at all.
  always_comb begin
    half_cur  = HALF_G6;
    dur_full  = D23;
    note_last = 3'd0;
    case (tune_q)
      2'd0: begin
        note_last = 3'd5;
        case (note_idx)
          3'd0:    begin half_cur = HALF_G6; dur_full = D23;    end
          3'd1:    begin half_cur = HALF_C7; dur_full = D23;    end
          3'd2:    begin half_cur = HALF_E7; dur_full = D23;    end
          3'd3:    begin half_cur = HALF_G7; dur_full = D23_22; end
          3'd4:    begin half_cur = HALF_E7; dur_full = D22;    end
          default: begin half_cur = HALF_G7; dur_full = D24;    end
        endcase
      end
      2'd1: begin
        note_last = 3'd1;
        if (note_idx == 3'd0) begin half_cur = HALF_E7; dur_full = D22; end
        else                  begin half_cur = HALF_C7; dur_full = D23; end
      end
      2'd2: begin
        note_last = 3'd1;
        if (note_idx == 3'd0) begin half_cur = HALF_G6; dur_full = D22; end
        else                  begin half_cur = HALF_G7; dur_full = D22; end
      end
      default: ;
    endcase
  end

  assign dur_cur   = dur_full >> DUR_SHIFT;
  assign last_note = (note_idx == note_last);
  assign last_rep  = (rep_cnt == reps_q);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (go) state_next = (tune == 2'd3) ? NEXT : PLAY;
      PLAY: if (dur_cnt == dur_cur - 25'd1) state_next = NEXT;
      NEXT: begin
        if (tune_q == 2'd3 || (last_note && last_rep)) state_next = IDLE;
        else                                            state_next = PLAY;
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // done only on a natural end of the tune; abort suppresses it.
  assign finish = (state == NEXT) && (state_next == IDLE) && !abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tune_q   <= 2'd0;
      reps_q   <= 2'd0;
      rep_cnt  <= 2'd0;
      note_idx <= 3'd0;
      dur_cnt  <= 25'd0;
      tone_cnt <= 32'd0;
      tone_q   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_next;
      done  <= finish;
      case (state)
        IDLE: begin
          if (state_next != IDLE) begin
            tune_q   <= tune;
            reps_q   <= reps;
            rep_cnt  <= 2'd0;
            note_idx <= 3'd0;
          end
        end
        PLAY: begin
          dur_cnt <= dur_cnt + 25'd1;
          if (tone_cnt == half_cur - 32'd1) begin
            tone_cnt <= 32'd0;
            tone_q   <= ~tone_q;
          end else begin
            tone_cnt <= tone_cnt + 32'd1;
          end
        end
        NEXT: begin
          tone_cnt <= 32'd0;
          if (last_note) begin
            note_idx <= 3'd0;
            rep_cnt  <= rep_cnt + 2'd1;
          end else begin
            note_idx <= note_idx + 3'd1;
          end
        end
        default: ;
      endcase
      // Every note starts with piezo high and fresh counters.
      if (state_next == PLAY && state != PLAY) begin
        dur_cnt  <= 25'd0;
        tone_cnt <= 32'd0;
        tone_q   <= 1'b1;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign sounding = busy && (tune_q != 2'd3);
  assign piezo    = sounding & tone_q;
  assign piezo_n  = sounding & ~tone_q;

endmodule
